// File: rtl/ysyx_25010008_lsu_pkg.sv
// Shared definitions for the load/store unit: access size encodings,
// AXI4-Lite response codes and the LSU control state enumeration.
package ysyx_25010008_lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_ILL  = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_REQ,
    S_WR_RESP,
    S_RESP
  } lsu_state_t;

endpackage

// File: rtl/ysyx_25010008_lsu_align.sv
// Combinational lane logic for the LSU.
//   offset/size/is_unsigned : byte offset, access size, zero-extend select
//   store_data -> lane_data/lane_strb : replicated store data and byte strobes
//   load_data  -> load_ext            : shifted and extended load result
//   misalign/illegal                  : access legality
//   eff_offset                        : offset actually used on the bus
// When CHECK_ALIGN is 0 a misaligned access is folded to offset 0, so lanes,
// strobes and the load shift all agree with the word-aligned bus address.
module ysyx_25010008_lsu_align
  import ysyx_25010008_lsu_pkg::*;
#(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] store_data,
  input  logic [31:0] load_data,
  output logic [1:0]  eff_offset,
  output logic [31:0] lane_data,
  output logic [3:0]  lane_strb,
  output logic [31:0] load_ext,
  output logic        misalign,
  output logic        illegal
);

  logic [31:0]        shifted;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  assign misalign   = ((size == SIZE_HALF) && offset[0]) ||
                      ((size == SIZE_WORD) && (offset != 2'd0));
  assign illegal    = (size == SIZE_ILL);
  assign eff_offset = (misalign && !CHECK_ALIGN) ? 2'd0 : offset;

  assign shifted = load_data >> {eff_offset, 3'b000};
  assign byte_s  = shifted[7:0];
  assign half_s  = shifted[15:0];

  always_comb begin
    lane_data = store_data;
    lane_strb = 4'b1111;
    load_ext  = shifted;
    case (size)
      SIZE_BYTE: begin
        lane_data = {4{store_data[7:0]}};
        lane_strb = 4'b0001 << eff_offset;
        load_ext  = is_unsigned ? {24'd0, shifted[7:0]} : 32'(byte_s);
      end
      SIZE_HALF: begin
        lane_data = {2{store_data[15:0]}};
        lane_strb = 4'b0011 << eff_offset;
        load_ext  = is_unsigned ? {16'd0, shifted[15:0]} : 32'(half_s);
      end
      default: begin
        lane_data = store_data;
        lane_strb = 4'b1111;
        load_ext  = shifted;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_25010008_lsu.sv
// Load/store unit: converts one EXU request at a time into a single
// AXI4-Lite read or write on arbiter master port 1, and returns one response.
//   clock, reset (async, active-low)
//   req_*  : EXU request (valid/ready, wen, addr, wdata, size, unsigned)
//   resp_* : response (valid/ready, rdata, err)
//   ar*/r*/aw*/w*/b* : AXI4-Lite master channels, all outputs registered
// Misaligned (when CHECK_ALIGN) and illegal-size requests finish with an error
// response and never touch the bus.
module ysyx_25010008_lsu
  import ysyx_25010008_lsu_pkg::*;
#(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  lsu_state_t  state, state_n;
  logic [1:0]  offset_q, size_q;
  logic        uns_q;
  logic        aw_done, w_done, aw_done_n, w_done_n;
  logic        accept, bad_req;
  logic [1:0]  al_offset, al_size, eff_offset;
  logic        al_uns, misalign, illegal;
  logic [31:0] lane_data, load_ext, eff_addr;
  logic [3:0]  lane_strb;

  // Incoming request fields drive the lane logic while idle; afterwards the
  // latched copies drive it so the load shift sees the accepted address.
  assign al_offset = (state == S_IDLE) ? req_addr[1:0] : offset_q;
  assign al_size   = (state == S_IDLE) ? req_size      : size_q;
  assign al_uns    = (state == S_IDLE) ? req_unsigned  : uns_q;

  ysyx_25010008_lsu_align #(
    .CHECK_ALIGN(CHECK_ALIGN)
  ) u_align (
    .offset      (al_offset),
    .size        (al_size),
    .is_unsigned (al_uns),
    .store_data  (req_wdata),
    .load_data   (rdata),
    .eff_offset  (eff_offset),
    .lane_data   (lane_data),
    .lane_strb   (lane_strb),
    .load_ext    (load_ext),
    .misalign    (misalign),
    .illegal     (illegal)
  );

  // Gated by reset so the EXU sees no ready while the unit is held in reset.
  assign req_ready = (state == S_IDLE) && reset;
  assign accept    = req_valid && (state == S_IDLE);
  assign bad_req   = illegal || (CHECK_ALIGN && misalign);
  assign eff_addr  = {req_addr[31:2], eff_offset};

  always_comb begin
    state_n   = state;
    aw_done_n = aw_done;
    w_done_n  = w_done;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
          if (bad_req)      state_n = S_RESP;
          else if (req_wen) state_n = S_WR_REQ;
          else              state_n = S_RD_ADDR;
        end
      end
      S_RD_ADDR: if (arready) state_n = S_RD_DATA;
      S_RD_DATA: if (rvalid)  state_n = S_RESP;
      S_WR_REQ: begin
        if (awvalid && awready) aw_done_n = 1'b1;
        if (wvalid && wready)   w_done_n  = 1'b1;
        if (aw_done_n && w_done_n) state_n = S_WR_RESP;
      end
      S_WR_RESP: if (bvalid)     state_n = S_RESP;
      S_RESP:    if (resp_ready) state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      offset_q   <= 2'd0;
      size_q     <= 2'd0;
      uns_q      <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      resp_valid <= 1'b0;
      araddr     <= '0;
      awaddr     <= '0;
      wdata      <= '0;
      wstrb      <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state   <= state_n;
      aw_done <= aw_done_n;
      w_done  <= w_done_n;
      // Handshake outputs follow the next state, so each is registered and
      // drops in the cycle after its own handshake.
      arvalid    <= (state_n == S_RD_ADDR);
      rready     <= (state_n == S_RD_DATA);
      awvalid    <= (state_n == S_WR_REQ) && !aw_done_n;
      wvalid     <= (state_n == S_WR_REQ) && !w_done_n;
      bready     <= (state_n == S_WR_RESP);
      resp_valid <= (state_n == S_RESP);
      if (accept) begin
        offset_q   <= eff_offset;
        size_q     <= req_size;
        uns_q      <= req_unsigned;
        resp_rdata <= '0;
        resp_err   <= bad_req;
        if (!bad_req && !req_wen) araddr <= eff_addr;
        if (!bad_req && req_wen) begin
          awaddr <= eff_addr;
          wdata  <= lane_data;
          wstrb  <= lane_strb;
        end
      end
      if ((state == S_RD_DATA) && rvalid) begin
        resp_err   <= (rresp != RESP_OKAY);
        resp_rdata <= (rresp != RESP_OKAY) ? '0 : load_ext;
      end
      if ((state == S_WR_RESP) && bvalid) begin
        resp_err <= (bresp != RESP_OKAY);
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25010008_lsu.sv
// Self-checking bench for the LSU: directed cases plus randomized requests
// against a behavioural byte-lane model and a cycle-stepped AXI-Lite slave.
module tb_ysyx_25010008_lsu;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready, awvalid, awready;
  logic        wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ysyx_25010008_lsu #(.CHECK_ALIGN(1'b1)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Load result from the byte-level view: pick nbytes starting at byte off,
  // then sign-extend by subtracting the range when the top bit is set.
  function automatic logic [31:0] model_load(input logic [31:0] d, input int off,
                                             input int nbytes, input logic uns);
    longint unsigned v, m;
    v = {32'd0, d} >> (8 * off);
    m = 64'd1 << (8 * nbytes);
    v = v % m;
    if (!uns && nbytes < 4 && v >= m / 2) v = v + 64'h1_0000_0000 - m;
    return v[31:0];
  endfunction

  task automatic run_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] sz, input logic uns, input logic [31:0] bus_rd,
                         input logic [1:0] bus_resp, input int ar_dly, input int r_dly,
                         input int aw_dly, input int w_dly, input int b_dly, input int rsp_dly,
                         output logic [31:0] got_rd, output logic got_err);
    int nbytes, off;
    logic local_err, exp_err;
    logic [31:0] exp_rd, exp_wd;
    logic [3:0] exp_strb;
    int ar_n, aw_n, w_n, ar_c, aw_c, w_c, r_c, b_c, rsp_c;
    bit ar_f, aw_f, w_f, r_f, b_f, done;
    ar_n = 0; aw_n = 0; w_n = 0; ar_c = 0; aw_c = 0; w_c = 0; r_c = 0; b_c = 0; rsp_c = 0;
    ar_f = 0; aw_f = 0; w_f = 0; r_f = 0; b_f = 0; done = 0;
    got_rd = 32'd0; got_err = 1'b0;
    off = int'(addr[1:0]);
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    local_err = (sz == 2'd3) || (off % nbytes != 0);
    exp_err = local_err || (bus_resp != 2'b00);
    exp_rd = (exp_err || wen) ? 32'd0 : model_load(bus_rd, off, nbytes, uns);
    exp_wd = (nbytes == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
             (nbytes == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
    exp_strb = 4'(((1 << nbytes) - 1) << off);

    @(negedge clock);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_wen = wen; req_addr = addr; req_wdata = wd;
    req_size = sz; req_unsigned = uns;
    @(posedge clock);
    for (int k = 1; k <= 400 && !done; k++) begin
      @(negedge clock);
      req_valid = 0; req_addr = $urandom; req_wdata = $urandom;
      req_size = 2'($urandom); req_unsigned = 1'($urandom); req_wen = 1'($urandom);
      if (k == 1) begin
        if (local_err)  chk("err_latency", resp_valid, 1);
        else if (!wen)  chk("ar_latency", arvalid, 1);
        else            chk("aw_w_latency", {awvalid, wvalid}, 2'b11);
      end
      chk("req_ready_busy", req_ready, 0);
      resp_ready = 0;
      if (resp_valid) begin
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("resp_err", resp_err, exp_err);
        if (rsp_c >= rsp_dly) begin
          resp_ready = 1; done = 1; got_rd = resp_rdata; got_err = resp_err;
        end
        rsp_c++;
      end
      bvalid = 0; bresp = 2'($urandom);
      if (aw_f && w_f && !b_f) begin
        if (b_c >= b_dly) begin
          bvalid = 1; bresp = bus_resp;
          chk("bready", bready, 1);
          if (bready) b_f = 1;
        end
        b_c++;
      end
      rvalid = 0; rdata = $urandom; rresp = 2'($urandom);
      if (ar_f && !r_f) begin
        if (r_c >= r_dly) begin
          rvalid = 1; rdata = bus_rd; rresp = bus_resp;
          chk("rready", rready, 1);
          if (rready) r_f = 1;
        end
        r_c++;
      end
      arready = 0;
      if (arvalid) begin
        chk("araddr", araddr, addr);
        if (ar_c >= ar_dly) begin arready = 1; ar_n++; ar_f = 1; end
        ar_c++;
      end
      awready = 0;
      if (awvalid) begin
        chk("awaddr", awaddr, addr);
        if (aw_c >= aw_dly) begin awready = 1; aw_n++; aw_f = 1; end
        aw_c++;
      end
      wready = 0;
      if (wvalid) begin
        chk("wdata", wdata, exp_wd);
        chk("wstrb", wstrb, exp_strb);
        if (w_c >= w_dly) begin wready = 1; w_n++; w_f = 1; end
        w_c++;
      end
    end
    if (!done) chk("timeout", 0, 1);
    @(negedge clock);
    resp_ready = 0; arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
    chk("req_ready_back", req_ready, 1);
    chk("resp_valid_drop", resp_valid, 0);
    chk("ar_beats", ar_n, (!local_err && !wen) ? 1 : 0);
    chk("aw_beats", aw_n, (!local_err && wen) ? 1 : 0);
    chk("w_beats", w_n, (!local_err && wen) ? 1 : 0);
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_size = 0; req_unsigned = 0;
    resp_ready = 0; arready = 0; rdata = 0; rresp = 0; rvalid = 0;
    awready = 0; wready = 0; bresp = 0; bvalid = 0;

    repeat (3) @(negedge clock);
    chk("rst_handshakes", {arvalid, awvalid, wvalid, rready, bready, resp_valid, req_ready}, 0);
    chk("rst_data", araddr | awaddr | wdata | resp_rdata, 0);
    chk("rst_strb_err", {wstrb, resp_err}, 0);
    reset = 1;
    #1 chk("req_ready_release", req_ready, 1);

    run_txn(0, 32'h8000_0003, 0, 2'd0, 0, 32'h80AA_BBCC, 2'b00, 0, 0, 0, 0, 0, 0, rd, er);
    chk("lb_signed_rdata", rd, 32'hFFFF_FF80);
    chk("lb_signed_err", er, 0);

    run_txn(0, 32'h8000_0002, 0, 2'd1, 1, 32'h8001_1234, 2'b00, 3, 1, 0, 0, 0, 0, rd, er);
    chk("lhu_rdata", rd, 32'h0000_8001);
    chk("lhu_err", er, 0);

    run_txn(1, 32'h8000_0001, 32'h0000_00AB, 2'd0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 0, rd, er);
    chk("sb_err", er, 0);
    chk("sb_rdata", rd, 0);

    run_txn(0, 32'h8000_0002, 0, 2'd2, 0, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 0, 0, 0, rd, er);
    chk("lw_misalign_err", er, 1);
    chk("lw_misalign_rdata", rd, 0);

    run_txn(1, 32'h8000_0010, 32'h1234_5678, 2'd2, 0, 0, 2'b10, 0, 0, 1, 0, 2, 4, rd, er);
    chk("sw_slverr", er, 1);

    run_txn(1, 32'h8000_0020, 32'h1234_5678, 2'd3, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, rd, er);
    chk("illegal_size_err", er, 1);

    run_txn(0, 32'h8000_0006, 0, 2'd1, 0, 32'hFEDC_1234, 2'b00, 0, 2, 0, 0, 0, 1, rd, er);
    chk("lh_signed_rdata", rd, 32'hFFFF_FEDC);

    for (int i = 0; i < 150; i++) begin
      logic [1:0] sz;
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      run_txn(1'($urandom), 32'h8000_0000 | ($urandom & 32'hFFF), $urandom, sz,
              1'($urandom), $urandom, ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b00,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), rd, er);
    end

    // Reset while the read data beat is outstanding.
    @(negedge clock);
    req_valid = 1; req_wen = 0; req_addr = 32'h8000_0100; req_size = 2'd2; req_unsigned = 0;
    @(negedge clock);
    req_valid = 0;
    chk("mid_arvalid", arvalid, 1);
    arready = 1;
    @(negedge clock);
    arready = 0;
    chk("mid_rready", rready, 1);
    #2 reset = 0;
    #1 chk("mid_reset_outputs", {arvalid, awvalid, wvalid, rready, bready, resp_valid, req_ready}, 0);
    @(negedge clock);
    reset = 1;
    #1 chk("mid_reset_release", req_ready, 1);

    run_txn(0, 32'h8000_0104, 0, 2'd2, 0, 32'h1357_9BDF, 2'b00, 1, 1, 0, 0, 0, 0, rd, er);
    chk("post_reset_rdata", rd, 32'h1357_9BDF);
    chk("post_reset_err", er, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
